synclk_gen: RTL and testbench

SYNCLK_GEN -- requirements
Module: synclk_gen

---
 rtl/synclk_gen.sv | 112 +++++++++++
 tb/tb_synclk_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/synclk_gen.sv
// Programmable sync-clock generator: emits Period-cycle pulses with HighTime
// cycles high, either as a fixed-length burst or continuously until stopped.
module synclk_gen #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic [CNT_W-1:0] Period,
  input  logic [CNT_W-1:0] HighTime,
  input  logic [7:0]       Burst,
  input  logic             ClearCout,
  output logic             Synclk,
  output logic [7:0]       SynclkCout,
  output logic             Busy,
  output logic             Done,
  output logic             CfgErr
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] period_q, high_q, phase_cnt;
  logic [7:0]       burst_q, pulse_cnt;
  logic             stop_pend;
  logic             cfg_ok, start_req, high_done, low_done, finish;
  logic             enter_high, done_nxt, cfg_err_nxt;

  // Synclk and Busy decode straight from the state register, so they are glitch-free.
  assign Synclk = (state == HIGH);
  assign Busy   = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    enter_high  = 1'b0;
    done_nxt    = 1'b0;
    cfg_err_nxt = 1'b0;
    cfg_ok      = (Period >= CNT_W'(2)) && (HighTime >= CNT_W'(1)) && (HighTime < Period);
    start_req   = (state == IDLE) && Start && !Stop;
    high_done   = (phase_cnt == high_q);
    low_done    = (phase_cnt == (period_q - high_q));
    // A Stop arriving in the final LOW cycle still lets this period finish cleanly.
    finish      = stop_pend || Stop || ((burst_q != 8'd0) && (pulse_cnt == burst_q));

    case (state)
      IDLE: begin
        if (start_req) begin
          if (cfg_ok) begin
            state_nxt  = HIGH;
            enter_high = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      HIGH: begin
        if (high_done) state_nxt = LOW;
      end
      LOW: begin
        if (low_done) begin
          if (finish) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = HIGH;
            enter_high = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      period_q   <= '0;
      high_q     <= '0;
      burst_q    <= '0;
      phase_cnt  <= '0;
      pulse_cnt  <= '0;
      stop_pend  <= 1'b0;
      SynclkCout <= '0;
      Done       <= 1'b0;
      CfgErr     <= 1'b0;
    end else begin
      state  <= state_nxt;
      Done   <= done_nxt;
      CfgErr <= cfg_err_nxt;

      if (start_req) begin
        period_q <= Period;
        high_q   <= HighTime;
        burst_q  <= Burst;
      end

      // Phase counter restarts at 1 on every state change so it equals cycles spent in the phase.
      if (state_nxt != state) phase_cnt <= CNT_W'(1);
      else if (state != IDLE) phase_cnt <= phase_cnt + CNT_W'(1);

      if (enter_high) pulse_cnt <= (state == IDLE) ? 8'd1 : pulse_cnt + 8'd1;

      if (state_nxt == IDLE) stop_pend <= 1'b0;
      else if (Stop)         stop_pend <= 1'b1;

      if (ClearCout)       SynclkCout <= 8'd0;
      else if (enter_high) SynclkCout <= SynclkCout + 8'd1;
    end
  end

endmodule

// File: tb/tb_synclk_gen.sv
// Scoreboard bench for synclk_gen: directed stimulus queues hand-derived
// per-cycle expectations that a negedge monitor pops and compares.
module tb_synclk_gen;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, stop, clear_cout;
  logic [CNT_W-1:0] period, high_time;
  logic [7:0]       burst;
  logic             synclk, busy, done, cfg_err;
  logic [7:0]       synclk_cout;

  typedef struct {
    int         target;
    string      name;
    logic       synclk;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic [7:0] cout;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  synclk_gen #(.CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Stop(stop),
    .Period(period), .HighTime(high_time), .Burst(burst), .ClearCout(clear_cout),
    .Synclk(synclk), .SynclkCout(synclk_cout), .Busy(busy), .Done(done), .CfgErr(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int target, input string name, input logic s, input logic b,
                          input logic d, input logic e, input logic [7:0] c);
    exp_t x;
    x.target = target; x.name = name;
    x.synclk = s; x.busy = b; x.done = d; x.cfg_err = e; x.cout = c;
    sb.push_back(x);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input exp_t x);
    compared++;
    if (x.target != cyc || synclk !== x.synclk || busy !== x.busy || done !== x.done ||
        cfg_err !== x.cfg_err || synclk_cout !== x.cout) begin
      mismatched++;
      $display("[TB] FAIL %s cyc=%0d (want cyc %0d) got synclk=%b busy=%b done=%b cfgerr=%b cout=%0d want synclk=%b busy=%b done=%b cfgerr=%b cout=%0d",
               x.name, cyc, x.target, synclk, busy, done, cfg_err, synclk_cout,
               x.synclk, x.busy, x.done, x.cfg_err, x.cout);
    end
  endtask

  // Monitor: every expectation due in this cycle is compared at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].target <= cyc) begin
      cur = sb.pop_front();
      check_output(cur);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear_cout = 1'b0;
    period = '0; high_time = '0; burst = '0;
    step_to(2);
    push_exp(cyc, "reset", 0, 0, 0, 0, 8'd0);
    reset = 1'b0;

    // Burst of three 5-cycle pulses; mid-run Start and config changes are ignored.
    step_to(4);
    b = cyc;
    period = 16'd5; high_time = 16'd2; burst = 8'd3; start = 1'b1;
    for (int j = 0; j < 3; j++)
      for (int p = 0; p < 5; p++)
        push_exp(b + 1 + 5 * j + p, "burst3", (p < 2), 1, 0, 0, 8'(j + 1));
    push_exp(b + 16, "burst3_done", 0, 0, 1, 0, 8'd3);
    push_exp(b + 17, "burst3_after", 0, 0, 0, 0, 8'd3);
    step_to(b + 1); start = 1'b0;
    step_to(b + 3); start = 1'b1; period = 16'd9; high_time = 16'd1; burst = 8'd1;
    step_to(b + 4); start = 1'b0;
    step_to(b + 17);

    // Rejected configurations, then the smallest legal one with Stop colliding with burst end.
    b = cyc;
    period = 16'd4; high_time = 16'd4; start = 1'b1;
    push_exp(b + 1, "cfgerr_hi_eq_per", 0, 0, 0, 1, 8'd3);
    push_exp(b + 2, "cfgerr_clear", 0, 0, 0, 0, 8'd3);
    push_exp(b + 3, "cfgerr_per1", 0, 0, 0, 1, 8'd3);
    push_exp(b + 4, "cfgerr_clear2", 0, 0, 0, 0, 8'd3);
    push_exp(b + 5, "min_high", 1, 1, 0, 0, 8'd4);
    push_exp(b + 6, "min_low", 0, 1, 0, 0, 8'd4);
    push_exp(b + 7, "min_done", 0, 0, 1, 0, 8'd4);
    push_exp(b + 8, "min_single_done", 0, 0, 0, 0, 8'd4);
    step_to(b + 1); start = 1'b0;
    step_to(b + 2); period = 16'd1; high_time = 16'd0; start = 1'b1;
    step_to(b + 3); start = 1'b0;
    step_to(b + 4); period = 16'd2; high_time = 16'd1; burst = 8'd1; start = 1'b1;
    step_to(b + 5); start = 1'b0; stop = 1'b1;
    step_to(b + 6); stop = 1'b0;
    step_to(b + 8);

    // Continuous run stopped during the second HIGH phase; next Start lands in the Done cycle.
    b = cyc;
    period = 16'd10; high_time = 16'd3; burst = 8'd0; start = 1'b1;
    for (int i = 1; i <= 20; i++)
      push_exp(b + i, "stop_run", (((i - 1) % 10) < 3), 1, 0, 0, 8'(5 + (i - 1) / 10));
    push_exp(b + 21, "stop_done", 0, 0, 1, 0, 8'd6);
    step_to(b + 1); start = 1'b0;
    step_to(b + 12); stop = 1'b1;
    step_to(b + 13); stop = 1'b0;
    step_to(b + 21);

    b = cyc;
    period = 16'd4; high_time = 16'd1; burst = 8'd0; start = 1'b1;
    push_exp(b + 1, "restart_in_done", 1, 1, 0, 0, 8'd7);
    for (int i = 2; i <= 4; i++) push_exp(b + i, "cont_low", 0, 1, 0, 0, 8'd7);
    push_exp(b + 5, "cont_high2", 1, 1, 0, 0, 8'd8);
    push_exp(b + 6, "cont_low2", 0, 1, 0, 0, 8'd8);
    push_exp(b + 7, "reset_mid_run", 0, 0, 0, 0, 8'd0);
    push_exp(b + 9, "start_stop_idle", 0, 0, 0, 0, 8'd0);
    push_exp(b + 10, "start_stop_idle2", 0, 0, 0, 0, 8'd0);
    step_to(b + 1); start = 1'b0;
    step_to(b + 6); reset = 1'b1;
    step_to(b + 7); reset = 1'b0;
    step_to(b + 8); period = 16'd5; high_time = 16'd2; start = 1'b1; stop = 1'b1;
    step_to(b + 9); start = 1'b0; stop = 1'b0;
    step_to(b + 10);

    // 255 pulses bring the counter to 255; the next wraps it, and a clear beats an increment.
    b = cyc;
    period = 16'd2; high_time = 16'd1; burst = 8'd255; start = 1'b1;
    push_exp(b + 1, "b255_first", 1, 1, 0, 0, 8'd1);
    push_exp(b + 2, "b255_first_low", 0, 1, 0, 0, 8'd1);
    push_exp(b + 509, "b255_last", 1, 1, 0, 0, 8'd255);
    push_exp(b + 510, "b255_last_low", 0, 1, 0, 0, 8'd255);
    push_exp(b + 511, "b255_done", 0, 0, 1, 0, 8'd255);
    push_exp(b + 512, "cout_wrap", 1, 1, 0, 0, 8'd0);
    push_exp(b + 513, "wrap_low", 0, 1, 0, 0, 8'd0);
    push_exp(b + 514, "clear_wins", 1, 1, 0, 0, 8'd0);
    push_exp(b + 515, "clear_low", 0, 1, 0, 0, 8'd0);
    push_exp(b + 516, "b2_done", 0, 0, 1, 0, 8'd0);
    push_exp(b + 517, "b2_idle", 0, 0, 0, 0, 8'd0);
    step_to(b + 1); start = 1'b0;
    step_to(b + 511); burst = 8'd2; start = 1'b1;
    step_to(b + 512); start = 1'b0;
    step_to(b + 513); clear_cout = 1'b1;
    step_to(b + 514); clear_cout = 1'b0;
    step_to(b + 520);

    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb.size());
      mismatched += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
